// File: rtl/ix_scan_gen.sv
// ix_scan_gen: request-matrix holder and row-major scanner feeding the
// ix-matrix checker. Each set bit the scanner lands on is granted and cleared.
// Optional build macro IX_SCAN_SKIP_EN: skip all-zero rows in a single cycle.
module ix_scan_gen #(
  parameter  int ROWS = 8,
  parameter  int COLS = 8,
  localparam int IW   = $clog2(ROWS),
  localparam int JW   = $clog2(COLS),
  localparam int CW   = $clog2(ROWS*COLS) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       set_vld,
  input  logic [IW-1:0]              set_row,
  input  logic [JW-1:0]              set_col,
  input  logic                       clr_vld,
  input  logic [IW-1:0]              clr_row,
  input  logic [JW-1:0]              clr_col,
  input  logic                       start,
  output logic [ROWS-1:0][COLS-1:0]  ix_o,
  output logic [IW-1:0]              i_o,
  output logic [JW-1:0]              j_o,
  output logic                       sel_o,
  output logic                       a_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [CW-1:0]              grant_cnt
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                    state_reg, state_next;
  logic [IW-1:0]             i_reg, i_next;
  logic [JW-1:0]             j_reg, j_next;
  logic [CW-1:0]             cnt_reg, cnt_next;
  logic [ROWS-1:0][COLS-1:0] ix_reg;
  logic                      grant;
  logic                      last_cell;
  logic                      last_row;
  logic                      last_col;
  logic                      row_skip;

  // Grant is derived purely from registers, so sel_o and a_o are identical.
  assign grant     = (state_reg == SCAN) & ix_reg[i_reg][j_reg];
  assign last_row  = (i_reg == IW'(ROWS-1));
  assign last_col  = (j_reg == JW'(COLS-1));
  assign last_cell = last_row & last_col;

`ifdef IX_SCAN_SKIP_EN
  // An empty row is only skipped when the scanner is at its first column.
  assign row_skip = (j_reg == '0) && (ix_reg[i_reg] == '0);
`else
  assign row_skip = 1'b0;
`endif

  assign ix_o      = ix_reg;
  assign i_o       = i_reg;
  assign j_o       = j_reg;
  assign sel_o     = grant;
  assign a_o       = grant;
  assign busy_o    = (state_reg == SCAN);
  assign done_o    = (state_reg == DONE);
  assign grant_cnt = cnt_reg;

  // Per-bit matrix update: set wins over clear and over this cycle's grant.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    for (genvar gj = 0; gj < COLS; gj++) begin : g_col
      always_ff @(posedge clk) begin
        if (rst) begin
          ix_reg[gi][gj] <= 1'b0;
        end else if (set_vld && set_row == IW'(gi) && set_col == JW'(gj)) begin
          ix_reg[gi][gj] <= 1'b1;
        end else if ((clr_vld && clr_row == IW'(gi) && clr_col == JW'(gj)) ||
                     (grant && i_reg == IW'(gi) && j_reg == JW'(gj))) begin
          ix_reg[gi][gj] <= 1'b0;
        end
      end
    end
  end

  // Scanner state, indices and grant counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      i_reg     <= '0;
      j_reg     <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      i_reg     <= i_next;
      j_reg     <= j_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic: start only in IDLE, one cell (or one empty row) per SCAN cycle.
  always_comb begin
    state_next = state_reg;
    i_next     = i_reg;
    j_next     = j_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = SCAN;
          i_next     = '0;
          j_next     = '0;
          cnt_next   = '0;
        end
      end
      SCAN: begin
        if (grant && cnt_reg < CW'(ROWS*COLS)) begin
          cnt_next = cnt_reg + CW'(1);
        end
        if (row_skip) begin
          if (last_row) begin
            state_next = DONE;
          end else begin
            i_next = i_reg + IW'(1);
            j_next = '0;
          end
        end else if (last_cell) begin
          state_next = DONE;
        end else if (last_col) begin
          i_next = i_reg + IW'(1);
          j_next = '0;
        end else begin
          j_next = j_reg + JW'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ix_scan_gen.sv
// Testbench for ix_scan_gen: cycle-by-cycle comparison against a linear-index
// scan model plus directed scenarios with hand-computed expectations.
module tb_ix_scan_gen;
  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int N    = ROWS * COLS;

  logic clk = 1'b0;
  logic rst, set_vld, clr_vld, start;
  logic [2:0] set_row, set_col, clr_row, clr_col;
  logic [ROWS-1:0][COLS-1:0] ix_o;
  logic [2:0] i_o, j_o;
  logic sel_o, a_o, busy_o, done_o;
  logic [6:0] grant_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ix_scan_gen #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk(clk), .rst(rst),
    .set_vld(set_vld), .set_row(set_row), .set_col(set_col),
    .clr_vld(clr_vld), .clr_row(clr_row), .clr_col(clr_col),
    .start(start),
    .ix_o(ix_o), .i_o(i_o), .j_o(j_o),
    .sel_o(sel_o), .a_o(a_o), .busy_o(busy_o), .done_o(done_o),
    .grant_cnt(grant_cnt)
  );

  // ---------------- behavioural model ----------------
  // The scan position is a single linear cell number k = i*COLS + j.
  bit  mm[ROWS][COLS];
  int  phase = 0;          // 0 idle, 1 scanning, 2 done pulse
  int  k = 0, mi = 0, mj = 0, mcnt = 0;
  bit  model_valid = 0;
  bit  m_g, m_sk;

  always @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) mm[r][c] = 0;
      phase = 0; k = 0; mi = 0; mj = 0; mcnt = 0;
      model_valid = 1;
    end else begin
      m_g  = (phase == 1) && mm[mi][mj];
      m_sk = 0;
`ifdef IX_SCAN_SKIP_EN
      if (phase == 1 && mj == 0) begin
        m_sk = 1;
        for (int c = 0; c < COLS; c++) if (mm[mi][c]) m_sk = 0;
      end
`endif
      if (clr_vld) mm[clr_row][clr_col] = 0;
      if (m_g) mm[mi][mj] = 0;
      if (set_vld) mm[set_row][set_col] = 1;
      case (phase)
        0: if (start) begin phase = 1; k = 0; mi = 0; mj = 0; mcnt = 0; end
        1: begin
          if (m_g && mcnt < N) mcnt++;
          k = m_sk ? k + COLS : k + 1;
          if (k >= N) phase = 2;
          else begin mi = k / COLS; mj = k % COLS; end
        end
        default: phase = 0;
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [N-1:0] exp_ix;
  logic         exp_sel;
  always @(negedge clk) begin
    if (model_valid) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) exp_ix[r*COLS+c] = mm[r][c];
      exp_sel = (phase == 1) && mm[mi][mj];
      checks++;
      if (ix_o !== exp_ix || i_o !== 3'(mi) || j_o !== 3'(mj) ||
          busy_o !== (phase == 1) || done_o !== (phase == 2) ||
          sel_o !== exp_sel || a_o !== exp_sel || grant_cnt !== 7'(mcnt)) begin
        errors++;
        $display("FAIL cyc_cmp t=%0t ix=%h/%h i=%0d/%0d j=%0d/%0d busy=%b/%b done=%b/%b sel=%b/%b a=%b/%b cnt=%0d/%0d",
                 $time, ix_o, exp_ix, i_o, mi, j_o, mj, busy_o, phase == 1, done_o, phase == 2,
                 sel_o, exp_sel, a_o, exp_sel, grant_cnt, mcnt);
      end
    end
  end

  // ---------------- event monitor ----------------
  int busy_n = 0, done_n = 0;
  int gq[$];
  always @(negedge clk) begin
    if (busy_o === 1'b1) busy_n++;
    if (done_o === 1'b1) done_n++;
    if (a_o === 1'b1) gq.push_back(int'(i_o) * COLS + int'(j_o));
  end

  // ---------------- helpers ----------------
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic set_bit(input int r, input int c);
    set_vld = 1; set_row = 3'(r); set_col = 3'(c);
    cyc();
    set_vld = 0;
  endtask

  task automatic clr_bit(input int r, input int c);
    clr_vld = 1; clr_row = 3'(r); clr_col = 3'(c);
    cyc();
    clr_vld = 0;
  endtask

  // Pulses start, then runs until done_o; returns cycle number of done (1 = first cycle after start edge).
  task automatic run_scan(input int extra_start_at, output int done_at);
    int n;
    start = 1;
    cyc();
    start = 0;
    n = 1;
    while (done_o !== 1'b1 && n < 200) begin
      start = (n == extra_start_at);
      cyc();
      n++;
    end
    start = 0;
    done_at = n;
  endtask

  // ---------------- stimulus ----------------
  int b0, d0, g0, done_at, exp_busy;

  initial begin
    rst = 1; set_vld = 0; clr_vld = 0; start = 0;
    set_row = 0; set_col = 0; clr_row = 0; clr_col = 0;
    cyc(); cyc();
    chk("reset_ix", 64'(ix_o), 64'h0);
    chk("reset_busy", 64'(busy_o), 64'h0);
    chk("reset_cnt", 64'(grant_cnt), 64'h0);
    rst = 0;
    cyc();

    // Set and clear on the same bit: set wins; clear alone then removes it.
    set_vld = 1; set_row = 1; set_col = 1;
    clr_vld = 1; clr_row = 1; clr_col = 1;
    cyc();
    set_vld = 0; clr_vld = 0;
    chk("setclr_both", 64'(ix_o[1][1]), 64'h1);
    clr_bit(1, 1);
    chk("clr_alone", 64'(ix_o[1][1]), 64'h0);

    // Reset mid-scan.
    set_bit(2, 5);
    d0 = done_n;
    start = 1; cyc(); start = 0;
    repeat (9) cyc();
    rst = 1; cyc(); rst = 0;
    chk("midrst_ix", 64'(ix_o), 64'h0);
    chk("midrst_busy", 64'(busy_o), 64'h0);
    chk("midrst_ij", 64'({i_o, j_o}), 64'h0);
    chk("midrst_cnt", 64'(grant_cnt), 64'h0);
    repeat (3) cyc();
    chk("midrst_nodone", 64'(done_n - d0), 64'h0);

    // Linear scan with three requests, plus ignored starts while busy and in DONE.
    set_bit(0, 0); set_bit(3, 4); set_bit(7, 7);
    b0 = busy_n; d0 = done_n; g0 = gq.size();
`ifdef IX_SCAN_SKIP_EN
    exp_busy = 29;
`else
    exp_busy = 64;
`endif
    run_scan(20, done_at);
    chk("lin_done_at", 64'(done_at), 64'(exp_busy + 1));
    start = 1; cyc(); start = 0;
    repeat (5) cyc();
    chk("lin_busy_cycles", 64'(busy_n - b0), 64'(exp_busy));
    chk("lin_done_pulses", 64'(done_n - d0), 64'h1);
    chk("lin_grant_cnt", 64'(grant_cnt), 64'd3);
    chk("lin_ix_empty", 64'(ix_o), 64'h0);
    chk("lin_idle", 64'(busy_o), 64'h0);
    chk("lin_ngrants", 64'(gq.size() - g0), 64'd3);
    if (gq.size() - g0 == 3) begin
      chk("lin_g0", 64'(gq[g0]), 64'd0);
      chk("lin_g1", 64'(gq[g0+1]), 64'd28);
      chk("lin_g2", 64'(gq[g0+2]), 64'd63);
    end

    // Set arriving in the cycle the scanner grants that same bit.
    set_bit(3, 4);
    g0 = gq.size();
    start = 1; cyc(); start = 0;
    begin
      int n = 0;
      while (!(busy_o === 1'b1 && i_o == 3 && j_o == 4) && n < 200) begin cyc(); n++; end
      chk("coll_reached", 64'(n < 200), 64'h1);
    end
    set_vld = 1; set_row = 3; set_col = 4;
    cyc();
    set_vld = 0;
    chk("coll_bit_kept", 64'(ix_o[3][4]), 64'h1);
    begin
      int n = 0;
      while (done_o !== 1'b1 && n < 200) begin cyc(); n++; end
      chk("coll_done_seen", 64'(n < 200), 64'h1);
    end
    cyc(); cyc();
    chk("coll_grant_cnt", 64'(grant_cnt), 64'd1);
    chk("coll_ngrants", 64'(gq.size() - g0), 64'd1);
    chk("coll_bit_after", 64'(ix_o[3][4]), 64'h1);
    clr_bit(3, 4);

`ifdef IX_SCAN_SKIP_EN
    // Only (5,2) set: seven skipped rows plus one full row.
    set_bit(5, 2);
    b0 = busy_n; g0 = gq.size();
    run_scan(-1, done_at);
    cyc(); cyc();
    chk("skip_busy", 64'(busy_n - b0), 64'd15);
    chk("skip_done_at", 64'(done_at), 64'd16);
    chk("skip_ngrants", 64'(gq.size() - g0), 64'd1);
    if (gq.size() - g0 == 1) chk("skip_g0", 64'(gq[g0]), 64'd42);
`endif

    // Full matrix: every cell granted, counter reaches its ceiling.
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) set_bit(r, c);
    chk("full_ix", 64'(ix_o), 64'hFFFF_FFFF_FFFF_FFFF);
    run_scan(-1, done_at);
    cyc(); cyc();
    chk("full_done_at", 64'(done_at), 64'd65);
    chk("full_grant_cnt", 64'(grant_cnt), 64'd64);
    chk("full_ix_empty", 64'(ix_o), 64'h0);

    repeat (2) cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ix_scan_gen.md
Name: ix_scan_gen

Overview:
- Upstream producer for the ix-matrix checker stage.
- Holds a ROWS x COLS request bit matrix written by set/clear ports.
- On start, a scanner FSM walks indices (i,j) in row-major order. Each set bit it lands on is granted (a_o) and auto-cleared.
- Drives the matrix, the current indices and the grant to the downstream checker, whose invariant is: sel_o implies a_o in the same cycle.

Parameters:
- ROWS, 8, number of matrix rows; power of 2, minimum 2.
- COLS, 8, number of matrix columns; power of 2, minimum 2.
- IW, $clog2(ROWS) (=3), row index width; derived, not overridden.
- JW, $clog2(COLS) (=3), column index width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- set_vld  in  1  set request bit at (set_row, set_col).
- set_row  in  IW  row index of set.
- set_col  in  JW  column index of set.
- clr_vld  in  1  clear request bit at (clr_row, clr_col).
- clr_row  in  IW  row index of clear.
- clr_col  in  JW  column index of clear.
- start  in  1  begin one full scan; accepted only in IDLE.
- ix_o  out  ROWS*COLS  matrix, packed [ROWS-1:0][COLS-1:0]; registered.
- i_o  out  IW  current row index; registered.
- j_o  out  JW  current column index; registered.
- sel_o  out  1  busy_o & ix_o[i_o][j_o].
- a_o  out  1  grant; equals sel_o, combinational from registers only.
- busy_o  out  1  FSM in SCAN.
- done_o  out  1  one-cycle pulse in DONE.
- grant_cnt  out  $clog2(ROWS*COLS)+1 (=7)  grants in current/last scan.

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - ix_o=0, i_o=0, j_o=0, grant_cnt=0, FSM=IDLE.
  - Hence busy_o=0, done_o=0, sel_o=0, a_o=0.
  - rst dominates all other inputs, including mid-scan; the scan is abandoned and there is no done pulse.
- Matrix update, applied at each clock edge in this priority:
  - set_vld sets its bit.
  - Else, if clr_vld or this cycle's grant targets that bit, it is cleared.
  - Set beats clear and grant on the same bit: a new request is never lost, and it is not re-granted this scan if the scanner has already passed it.
  - Set and clear on different bits both apply.
  - Writes are legal in every state.
- FSM states: IDLE, SCAN, DONE.
  - IDLE:
    - i_o/j_o hold their values.
    - start=1 -> SCAN with i_o=0, j_o=0, grant_cnt=0.
  - SCAN, once per cycle:
    - If ix_o[i_o][j_o]=1, then a_o=1, the bit clears at the edge, and grant_cnt increments.
    - Advance: j_o+1, or wrap j_o to 0 with i_o+1.
    - At (ROWS-1, COLS-1), after evaluating that cell -> DONE; i_o/j_o hold at the last cell.
  - DONE: done_o=1 for one cycle -> IDLE. start in DONE is ignored.
- start while busy_o=1 is ignored; there is no restart.
- Latency with start sampled at edge N:
  - busy_o=1 for exactly ROWS*COLS cycles (64) after N.
  - done_o in the 65th cycle after N.
  - Next start is accepted from the 66th cycle.
- grant_cnt:
  - Saturates at ROWS*COLS (64), so it cannot overflow.
  - Holds its value after DONE until the next accepted start.
- Index wrap: i_o/j_o never exceed ROWS-1/COLS-1; the IW/JW arithmetic wraps naturally.
- The downstream property "sel_o |-> a_o" holds by construction in every cycle, including the reset cycle and IDLE.

Optional Feature:
- Macro: IX_SCAN_SKIP_EN.
- Defined: in SCAN with j_o=0, if row i_o is all-zero, the scanner skips the row in one cycle (i_o+1, j_o=0, or -> DONE if it was the last row).
  - busy_o duration becomes variable: minimum ROWS cycles (8) for an empty matrix.
  - done_o still follows the last SCAN cycle by one cycle.
  - A bit set into an already-skipped row is not granted this scan.
- Undefined: fixed ROWS*COLS-cycle linear scan as above; no skip logic is synthesised.

Test Plan:
- Reset mid-scan: set (2,5), start, assert rst at cycle 10 -> next cycle ix_o=0, busy_o=0, i_o=j_o=0, grant_cnt=0, and no done_o.
- Linear scan: set (0,0), (3,4), (7,7), then start -> a_o pulses when (i_o,j_o) = (0,0), (3,4), (7,7); busy_o=1 for 64 cycles; done_o at cycle 65; grant_cnt=3; ix_o=0.
- Set/grant collision: set (3,4) in the same cycle the scanner grants (3,4) -> bit remains 1 after the edge; grant_cnt still counts the grant; no second grant this scan.
- Set+clear collision: in IDLE, set_vld and clr_vld both at (1,1) -> ix_o[1][1]=1. Clear alone next cycle -> 0.
- Ignored start: pulse start at busy cycle 20 and during DONE -> no restart; exactly one done_o; return to IDLE.
- IX_SCAN_SKIP_EN only: only (5,2) set, then start -> rows 0-4 and 6-7 take one cycle each, row 5 takes 8 cycles; busy_o=15 cycles, a single a_o at (5,2), done_o next cycle.
